// File: rtl/vga_frame_ctrl_if.sv
// Board RAM read port between vga_frame_ctrl (master) and the playfield RAM (slave).
// Read data is expected exactly one clock after cell_addr/cell_rd.
interface vga_frame_ctrl_if;
    logic [7:0] cell_addr;
    logic       cell_rd;
    logic [2:0] cell_color;

    modport master (output cell_addr, output cell_rd, input  cell_color);
    modport slave  (input  cell_addr, input  cell_rd, output cell_color);
endinterface

// File: rtl/vga_frame_ctrl.sv
// VGA timing generator and playfield pixel fetcher for the Tetris display.
// Optional macro VGA_GRID_LINES_EN draws a blue grid on the first row/column of every cell.
module vga_frame_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PF_X0    = 240,
    parameter int PF_Y0    = 80,
    parameter int CELL_SH  = 4,
    parameter int PF_COLS  = 10,
    parameter int PF_ROWS  = 20
) (
    input  logic             clk,
    input  logic             reset,
    vga_frame_ctrl_if.master ram,
    output logic             R,
    output logic             G,
    output logic             B,
    output logic             hs,
    output logic             vs,
    output logic             frame_start,
    output logic             vblank
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] PF_X0_C   = 10'(PF_X0);
    localparam logic [9:0] PF_Y0_C   = 10'(PF_Y0);
    localparam logic [9:0] PF_X1_C   = 10'(PF_X0 + (PF_COLS << CELL_SH));
    localparam logic [9:0] PF_Y1_C   = 10'(PF_Y0 + (PF_ROWS << CELL_SH));
    localparam logic [7:0] PF_COLS_C = 8'(PF_COLS);

    // Stage 0: pixel divider and raster counters
    logic [DIV_W-1:0] div;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             tick;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Raster decode feeding stage 1
    logic [9:0] pf_dx;
    logic [9:0] pf_dy;
    logic [7:0] row_c;
    logic [7:0] col_c;
    logic [7:0] addr_c;
    logic       in_pf_c;
    logic       active_c;

    assign pf_dx    = h - PF_X0_C;
    assign pf_dy    = v - PF_Y0_C;
    assign row_c    = 8'(pf_dy >> CELL_SH);
    assign col_c    = 8'(pf_dx >> CELL_SH);
    assign addr_c   = row_c * PF_COLS_C + col_c;
    assign in_pf_c  = (h >= PF_X0_C) && (h < PF_X1_C) && (v >= PF_Y0_C) && (v < PF_Y1_C);
    assign active_c = (h < H_ACT_C) && (v < V_ACT_C);

    logic s1_active, s1_in_pf, s1_hsync, s1_vsync;
    logic s2_active, s2_in_pf, s2_hsync, s2_vsync;

`ifdef VGA_GRID_LINES_EN
    logic grid_c;
    logic s1_grid, s2_grid;

    assign grid_c = in_pf_c && ((pf_dx[CELL_SH-1:0] == '0) || (pf_dy[CELL_SH-1:0] == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_grid <= 1'b0;
            s2_grid <= 1'b0;
        end else begin
            s1_grid <= grid_c;
            s2_grid <= s1_grid;
        end
    end
`endif

    // Stage 1: RAM request plus flags; frame_start/vblank leave here for the game logic
    always_ff @(posedge clk) begin
        if (reset) begin
            ram.cell_addr <= '0;
            ram.cell_rd   <= 1'b0;
            s1_active     <= 1'b0;
            s1_in_pf      <= 1'b0;
            s1_hsync      <= 1'b0;
            s1_vsync      <= 1'b0;
            frame_start   <= 1'b0;
            vblank        <= 1'b0;
        end else begin
            ram.cell_rd <= in_pf_c;
            if (in_pf_c) begin
                ram.cell_addr <= addr_c;
            end
            s1_active   <= active_c;
            s1_in_pf    <= in_pf_c;
            s1_hsync    <= (h >= HS_START) && (h < HS_END);
            s1_vsync    <= (v >= VS_START) && (v < VS_END);
            frame_start <= tick && (h == '0) && (v == '0);
            vblank      <= (v >= V_ACT_C);
        end
    end

    // Stage 2: flags wait alongside the RAM read
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_active <= 1'b0;
            s2_in_pf  <= 1'b0;
            s2_hsync  <= 1'b0;
            s2_vsync  <= 1'b0;
        end else begin
            s2_active <= s1_active;
            s2_in_pf  <= s1_in_pf;
            s2_hsync  <= s1_hsync;
            s2_vsync  <= s1_vsync;
        end
    end

    logic [2:0] pix_c;

    // NOTE: assign every combinational output a default first so no path infers a latch.
    always_comb begin
        pix_c = 3'b000;
        if (s2_active && s2_in_pf) begin
            pix_c = ram.cell_color;
`ifdef VGA_GRID_LINES_EN
            if (s2_grid) begin
                pix_c = 3'b001;
            end
`endif
        end
    end

    // Stage 3: pin registers; sync and colour share the same three-clock latency
    always_ff @(posedge clk) begin
        if (reset) begin
            R  <= 1'b0;
            G  <= 1'b0;
            B  <= 1'b0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            {R, G, B} <= pix_c;
            hs        <= ~s2_hsync;
            vs        <= ~s2_vsync;
        end
    end

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl on a scaled raster (200x110 pixels, 4x4 cells) so a full frame fits the run.
// Counters after edge c: pixel p=c/2, h=p%200, v=(p/200)%110; address outputs show that pixel at c+1, pins at c+3.
module tb_vga_frame_ctrl;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 160;
    localparam int H_FP     = 8;
    localparam int H_SYNC   = 24;
    localparam int H_BP     = 8;
    localparam int V_ACTIVE = 100;
    localparam int V_FP     = 4;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 4;
    localparam int PF_X0    = 40;
    localparam int PF_Y0    = 10;
    localparam int CELL_SH  = 2;
    localparam int PF_COLS  = 10;
    localparam int PF_ROWS  = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic R, G, B, hs, vs, frame_start, vblank;
    logic [2:0] ram_xor = 3'b111;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    vga_frame_ctrl_if bus ();

    vga_frame_ctrl #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PF_X0(PF_X0), .PF_Y0(PF_Y0), .CELL_SH(CELL_SH), .PF_COLS(PF_COLS), .PF_ROWS(PF_ROWS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ram(bus),
        .R(R),
        .G(G),
        .B(B),
        .hs(hs),
        .vs(vs),
        .frame_start(frame_start),
        .vblank(vblank)
    );

    always #5 clk = ~clk;

    // Board RAM model: one-clock read latency, contents addr[2:0]^ram_xor
    always @(posedge clk) bus.cell_color <= bus.cell_addr[2:0] ^ ram_xor;

    // Edges since reset was last sampled low
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: got cyc=%0d required %0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({R, G, B, hs, vs, bus.cell_rd, frame_start, vblank} !== 8'b000_11_0_0_0) begin
                errors++;
                $display("FAIL reset_outputs: got RGB,hs,vs,rd,fs,vb=%b required 00011000",
                         {R, G, B, hs, vs, bus.cell_rd, frame_start, vblank});
            end
        end
        checks++;
        if (bus.cell_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d required 0", bus.cell_addr);
        end
        reset = 1'b0;
        wait_cyc(1);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_early: got %b required 0", frame_start);
        end
        wait_cyc(2);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL fs_first: got %b required 1", frame_start);
        end
        wait_cyc(3);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_width: got %b required 0", frame_start);
        end
    endtask

    // Sync region h=168..191 -> hs low at cycles 339..386 and 739..786
    task automatic test_hsync();
        int lows = 0;
        int first = -1;
        int last = -1;
        for (int k = 4; k <= 802; k++) begin
            wait_cyc(k);
            if (hs === 1'b0) begin
                lows++;
                if (first < 0) first = k;
                last = k;
            end
        end
        checks++;
        if (lows != 96) begin
            errors++;
            $display("FAIL hs_low_count: got %0d required 96", lows);
        end
        checks++;
        if (first != 339) begin
            errors++;
            $display("FAIL hs_first_low: got %0d required 339", first);
        end
        checks++;
        if (last != 786) begin
            errors++;
            $display("FAIL hs_last_low: got %0d required 786", last);
        end
    endtask

    task automatic test_pf_addr();
        wait_cyc(4080);
        checks++;
        if (bus.cell_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_h39: got %b required 0", bus.cell_rd);
        end
        wait_cyc(4081);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL addr_topleft: got rd=%b addr=%0d required rd=1 addr=0", bus.cell_rd, bus.cell_addr);
        end
        wait_cyc(4159);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b1, 8'd9}) begin
            errors++;
            $display("FAIL addr_topright: got rd=%b addr=%0d required rd=1 addr=9", bus.cell_rd, bus.cell_addr);
        end
        wait_cyc(4161);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b0, 8'd9}) begin
            errors++;
            $display("FAIL addr_hold_right: got rd=%b addr=%0d required rd=0 addr=9", bus.cell_rd, bus.cell_addr);
        end
    endtask

    // Cell 11 with ram_xor=111 reads 100; (44,14) is a cell corner, (45,15) is interior
    task automatic test_grid();
        logic [2:0] exp_corner;
`ifdef VGA_GRID_LINES_EN
        exp_corner = 3'b001;
`else
        exp_corner = 3'b100;
`endif
        wait_cyc(5691);
        checks++;
        if ({R, G, B} !== exp_corner) begin
            errors++;
            $display("FAIL grid_corner: got %b required %b", {R, G, B}, exp_corner);
        end
        wait_cyc(6093);
        checks++;
        if ({R, G, B} !== 3'b100) begin
            errors++;
            $display("FAIL grid_interior: got %b required 100", {R, G, B});
        end
        ram_xor = 3'b001;
    endtask

    task automatic test_colour();
        logic [2:0] exp_edge;
`ifdef VGA_GRID_LINES_EN
        exp_edge = 3'b001;
`else
        exp_edge = 3'b011;
`endif
        wait_cyc(12443);
        checks++;
        if ({R, G, B} !== 3'b000) begin
            errors++;
            $display("FAIL rgb_left_of_pf: got %b required 000", {R, G, B});
        end
        wait_cyc(12482);
        checks++;
        if ({R, G, B} !== 3'b000) begin
            errors++;
            $display("FAIL rgb_h39: got %b required 000", {R, G, B});
        end
        wait_cyc(12483);
        checks++;
        if ({R, G, B} !== exp_edge) begin
            errors++;
            $display("FAIL rgb_h40: got %b required %b", {R, G, B}, exp_edge);
        end
        wait_cyc(12525);
        checks++;
        if ({R, G, B} !== 3'b110) begin
            errors++;
            $display("FAIL rgb_cell55: got %b required 110", {R, G, B});
        end
        wait_cyc(12526);
        checks++;
        if ({R, G, B} !== 3'b110) begin
            errors++;
            $display("FAIL rgb_cell55_repeat: got %b required 110", {R, G, B});
        end
    endtask

    task automatic test_bottom();
        wait_cyc(35759);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b1, 8'd199}) begin
            errors++;
            $display("FAIL addr_last: got rd=%b addr=%0d required rd=1 addr=199", bus.cell_rd, bus.cell_addr);
        end
        wait_cyc(36081);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b0, 8'd199}) begin
            errors++;
            $display("FAIL rd_below_pf: got rd=%b addr=%0d required rd=0 addr=199", bus.cell_rd, bus.cell_addr);
        end
    endtask

    task automatic test_vblank_vsync();
        int lows = 0;
        wait_cyc(40000);
        checks++;
        if (vblank !== 1'b0) begin
            errors++;
            $display("FAIL vblank_v99: got %b required 0", vblank);
        end
        wait_cyc(40001);
        checks++;
        if (vblank !== 1'b1) begin
            errors++;
            $display("FAIL vblank_v100: got %b required 1", vblank);
        end
        for (int k = 41500; k <= 42500; k++) begin
            wait_cyc(k);
            if (vs === 1'b0) lows++;
            if (k == 41602 || k == 42403) begin
                checks++;
                if (vs !== 1'b1) begin
                    errors++;
                    $display("FAIL vs_edge_high: cyc %0d got %b required 1", k, vs);
                end
            end
            if (k == 41603 || k == 42402) begin
                checks++;
                if (vs !== 1'b0) begin
                    errors++;
                    $display("FAIL vs_edge_low: cyc %0d got %b required 0", k, vs);
                end
            end
        end
        checks++;
        if (lows != 800) begin
            errors++;
            $display("FAIL vs_low_count: got %0d required 800", lows);
        end
    endtask

    task automatic test_frame_wrap();
        wait_cyc(44000);
        checks++;
        if ({vblank, frame_start} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_before: got vb,fs=%b required 10", {vblank, frame_start});
        end
        wait_cyc(44001);
        checks++;
        if ({vblank, frame_start} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_v0: got vb,fs=%b required 00", {vblank, frame_start});
        end
        wait_cyc(44002);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL fs_period: got %b required 1", frame_start);
        end
        wait_cyc(44003);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_period_width: got %b required 0", frame_start);
        end
    endtask

    // Second frame, pins showing pixel (59,31) = cell 54 -> 110^001 = 111, then one-clock reset
    task automatic test_mid_reset();
        wait_cyc(56522);
        checks++;
        if ({R, G, B, hs} !== 4'b1111) begin
            errors++;
            $display("FAIL pre_reset_pixel: got RGB,hs=%b required 1111", {R, G, B, hs});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({R, G, B, hs, vs, bus.cell_rd, frame_start, vblank, bus.cell_addr} !== {8'b000_11_0_0_0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got RGB,hs,vs,rd,fs,vb=%b addr=%0d required 00011000 addr=0",
                     {R, G, B, hs, vs, bus.cell_rd, frame_start, vblank}, bus.cell_addr);
        end
        wait_cyc(2);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_fs: got %b required 1", frame_start);
        end
        wait_cyc(4081);
        checks++;
        if ({bus.cell_rd, bus.cell_addr} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL restart_addr: got rd=%b addr=%0d required rd=1 addr=0", bus.cell_rd, bus.cell_addr);
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_pf_addr();
        test_grid();
        test_colour();
        test_bottom();
        test_vblank_vsync();
        test_frame_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
